// File: rtl/keypad_scan_ctrl_pkg.sv
// keypad_pkg: shared codes, state encoding and the per-column row decoder
// for the 4-column x 3-row keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_MULTI = 4'hE;
  localparam logic [3:0] COL_RESET = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED
  } state_e;

  // Column {A,B,C,D} one-hot, rows {E,F,G}; returns 1..c, NONE or MULTI.
  function automatic logic [3:0] key_decode(input logic [3:0] col, input logic [2:0] rows);
    logic [3:0] base;
    logic [3:0] code;
    case (col)
      4'b1000: base = 4'd0;
      4'b0100: base = 4'd3;
      4'b0010: base = 4'd6;
      4'b0001: base = 4'd9;
      default: base = 4'd0;
    endcase
    case (rows)
      3'b000:  code = KEY_NONE;
      3'b100:  code = base + 4'd1;
      3'b010:  code = base + 4'd2;
      3'b001:  code = base + 4'd3;
      default: code = KEY_MULTI;
    endcase
    if (!(col inside {4'b1000, 4'b0100, 4'b0010, 4'b0001})) code = KEY_NONE;
    return code;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Key event interface: controller (master) presents key_code/key_valid with
// status flags; consumer (slave) answers with key_ready.
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code, key_valid, key_held, overrun,
    input  key_ready
  );

  modport slave (
    input  key_code, key_valid, key_held, overrun,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl_timer.sv
// keypad_scan_timer: column dwell counter, one-hot column rotation A->B->C->D,
// row sample strobe and end-of-scan pulse.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCN_rate = 1000,
  parameter int SETTLE   = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  output logic [3:0] col_o,
  output logic       sample_en_o,
  output logic       scan_done_o
);

  localparam int DW = $clog2(SCN_rate);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_q, col_d;
  logic          last;

  assign last = (dwell_q == DW'(SCN_rate - 1));

  // Dwell and column registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dwell_q <= '0;
      col_q   <= COL_RESET;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

  // Advance dwell; rotate to the next column as the dwell wraps.
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    col_d   = col_q;
    if (last) begin
      dwell_d = '0;
      col_d   = {col_q[0], col_q[3:1]};
    end
  end

  assign col_o       = col_q;
  assign sample_en_o = (dwell_q == DW'(SETTLE));
  assign scan_done_o = last && col_q[0];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: keypad scan sequencer with per-scan key accumulation,
// scan-level debounce FSM and valid/ready event output with sticky overrun.
// Optional auto-repeat while held: define KEYPAD_SCAN_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCN_rate       = 1000,
  parameter int SETTLE         = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  output logic [3:0]                 col_out,
  input  logic [2:0]                 row_in,
  keypad_scan_ctrl_if.master         kp
);

  if (SCN_rate < 4 || SETTLE >= SCN_rate || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scan_ctrl: illegal parameter combination");
  end

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic          sample_en, scan_done;
  logic [3:0]    col_res, base, eff;
  logic [3:0]    scan_code_q, scan_code_d;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic          emit, hs;
  logic [3:0]    emit_code;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          overrun_q, overrun_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  keypad_scan_timer #(
    .SCN_rate (SCN_rate),
    .SETTLE   (SETTLE)
  ) u_timer (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .col_o       (col_out),
    .sample_en_o (sample_en),
    .scan_done_o (scan_done)
  );

  // Fold each column's decode into the running scan code; column A restarts it.
  always_comb begin
    col_res     = key_decode(col_out, row_in);
    base        = col_out[3] ? KEY_NONE : scan_code_q;
    scan_code_d = scan_code_q;
    if (sample_en) begin
      if (col_res == KEY_NONE)                         scan_code_d = base;
      else if (col_res == KEY_MULTI || base != KEY_NONE) scan_code_d = KEY_MULTI;
      else                                             scan_code_d = col_res;
    end
  end

  assign eff = (scan_code_q == KEY_MULTI) ? KEY_NONE : scan_code_q;

  // Debounce / press / release FSM, evaluated once per completed scan.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_d     = rel_q;
    emit      = 1'b0;
    emit_code = cand_q;
`ifdef KEYPAD_SCAN_REPEAT_EN
    rpt_d     = rpt_q;
`endif
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (eff != KEY_NONE) begin
            cand_d = eff;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              emit      = 1'b1;
              emit_code = eff;
              state_d   = ST_PRESSED;
              rel_d     = '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rpt_d     = '0;
`endif
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (eff == KEY_NONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (eff == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
              emit    = 1'b1;
              state_d = ST_PRESSED;
              rel_d   = '0;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rpt_d   = '0;
`endif
            end
          end else begin
            cand_d = eff;
            cnt_d  = CW'(1);
          end
        end
        ST_PRESSED: begin
          if (eff == KEY_NONE) begin
            rel_d = rel_q + 1'b1;
            if (rel_q + 1'b1 == CW'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
              rel_d   = '0;
              cnt_d   = '0;
            end
          end else begin
            rel_d = '0;
          end
`ifdef KEYPAD_SCAN_REPEAT_EN
          if (eff == cand_q) begin
            rpt_d = rpt_q + 1'b1;
            if (rpt_q + 1'b1 == RW'(REPEAT_SCANS)) begin
              emit  = 1'b1;
              rpt_d = '0;
            end
          end else begin
            rpt_d = '0;
          end
`else
          // One event per press; nothing further while held.
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output slot: a same-cycle handshake frees the slot for a new event;
  // otherwise an emit into an occupied slot is dropped and flagged.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    hs          = key_valid_q && kp.key_ready;
    if (hs) key_valid_d = 1'b0;
    if (emit) begin
      if (key_valid_q && !hs) begin
        overrun_d = 1'b1;
      end else begin
        key_code_d  = emit_code;
        key_valid_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_code_q <= KEY_NONE;
      state_q     <= ST_IDLE;
      cand_q      <= KEY_NONE;
      cnt_q       <= '0;
      rel_q       <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rpt_q       <= '0;
`endif
    end else begin
      scan_code_q <= scan_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rpt_q       <= rpt_d;
`endif
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.overrun   = overrun_q;
  assign kp.key_held  = (state_q == ST_PRESSED);

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Self-contained scan sequencer for the 4-column × 3-row membrane keypad. It drives the one-hot column lines, samples the row lines after a settle delay, and assembles one key code per full scan. Key codes are debounced across consecutive scans, and one event per press is delivered to downstream logic (7-seg/display, entry FSMs) over a valid/ready handshake. It replaces free-running scan-plus-latch logic with a single-clock, fully synchronous controller.

Parameters:
SCN_rate, 1000, sys_clk cycles each column is driven (dwell); min 4.
SETTLE, 8, cycles after a column change before row_in is sampled; must be < SCN_rate.
DEBOUNCE_SCANS, 4, consecutive identical full-scan codes needed to accept a press; the same count of empty scans is needed to accept a release; min 1.
REPEAT_SCANS, 64, full scans between auto-repeat events (used only with KEYPAD_SCAN_REPEAT_EN).

Ports:
sys_clk  in  1  system clock.
sys_rst  in  1  asynchronous, active-high reset.
col_out  out  4  {A,B,C,D} one-hot column drive, active-high.
row_in  in  3  {E,F,G} row sense, active-high.
key_code  out  4  accepted key: 1..9, a, b, c.
key_valid  out  1  event pending.
key_ready  in  1  consumer accepts when key_valid && key_ready.
key_held  out  1  high while in PRESSED.
overrun  out  1  sticky; event dropped because the previous one was unconsumed.

Behaviour:
- Reset values: col_out=4'b1000, key_code=4'hF, key_valid=0, key_held=0, overrun=0, state=IDLE, all counters 0. Reset mid-scan or mid-debounce aborts everything; no event is emitted.
- Dwell counter runs 0..SCN_rate-1. At SCN_rate-1, col_out rotates A→B→C→D→A and the counter wraps to 0.
- Sample: on the cycle dwell==SETTLE, decode row_in for the current column.
- Per-column decode: exactly one row high gives the key. Column A: E/F/G = 1/2/3. B: 4/5/6. C: 7/8/9. D: a/b/c. Zero rows gives NONE (4'hF). Two or more rows gives MULTI.
- Scan accumulation: scan_code starts at NONE when column A begins. The first valid key is stored. A second valid key, or any MULTI result, in the same scan forces MULTI for the whole scan.
- scan_done: a one-cycle pulse on the cycle dwell==SCN_rate-1 with column D active.
- The FSM updates only on scan_done. MULTI is treated as NONE for all transitions.
- IDLE: if scan_code≠NONE, set cand=scan_code, cnt=1, go to DEBOUNCE. If DEBOUNCE_SCANS==1, go straight to the accept path.
- DEBOUNCE:
  - scan_code==cand: cnt++. When cnt reaches DEBOUNCE_SCANS, emit cand and go to PRESSED.
  - scan_code is a different non-NONE key: restart with cand=new code, cnt=1.
  - scan_code is NONE: go to IDLE.
- PRESSED: key_held=1. rel_cnt counts consecutive NONE scans and clears on any non-NONE scan. When rel_cnt==DEBOUNCE_SCANS, go to IDLE. A different key while in PRESSED emits nothing.
- Emit:
  - key_code and key_valid are registered on the same scan_done edge, so key_valid is high the following cycle.
  - key_valid holds, with key_code stable, until the handshake completes. It deasserts on the edge after key_valid&&key_ready.
  - Emit while key_valid && !key_ready: the new event is dropped, key_code keeps the old value, and overrun is set. overrun clears only on reset.
  - Emit in the same cycle as a handshake completes: key_code loads the new event and key_valid stays high; this is not an overrun.
- Latency: press-to-key_valid is at most (DEBOUNCE_SCANS+1) scan periods (scan period = 4·SCN_rate cycles).

Optional Feature:
KEYPAD_SCAN_REPEAT_EN.
- Defined: in PRESSED, a repeat counter increments on each scan_done where scan_code==cand. When it reaches REPEAT_SCANS, the block re-emits cand (same overrun rules) and the counter clears. The counter also clears on entry to PRESSED and on any mismatching scan.
- Undefined: exactly one event per press; REPEAT_SCANS is ignored and no repeat counter is synthesised.

Decomposition:
- Package keypad_pkg:
  - KEY_NONE=4'hF and a MULTI marker.
  - State encoding: IDLE, DEBOUNCE, PRESSED.
  - Column-reset constant 4'b1000.
  - Pure function key_decode(col, rows) returning the 4-bit code or NONE/MULTI.
- Sub-module keypad_scan_timer: dwell counter, column rotation, and the sample_en/scan_done pulses.
- Top level: accumulation, FSM, and output handshake.

Test Plan:
Unless noted, all scenarios use SCN_rate=16, SETTLE=4, DEBOUNCE_SCANS=3, so one scan is 64 cycles.
- Reset then idle for 10 scans → col_out cycles 1000,0100,0010,0001 every 16 cycles; key_valid stays 0, key_code=F.
- Hold key "5" (F high while col B is active) steadily, key_ready=1 → one key_valid pulse with key_code=4'h5 one cycle after the 3rd scan_done; key_held=1. Release → key_held=0 after 3 empty scans; no second event.
- Bounce "8" present in scans 1 and 3 only, then stable → the count restarts each time; an event is emitted only after 3 consecutive scans containing "8".
- Hold "1" and "c" together → every scan is MULTI; no event and no overrun.
- key_ready=0, press "2", release, press "3" → key_code stays 2, key_valid stays 1, overrun=1. Then key_ready=1 → key_valid drops the next cycle.
- With KEYPAD_SCAN_REPEAT_EN and REPEAT_SCANS=2, hold "9" → first event after 3 scans, then an event every 2 scans. Assert sys_rst mid-hold → all outputs return to reset values immediately.
